// File: rtl/key_voice_arbiter.sv
// Shares one square-wave tone generator among four debounced piano keys:
// last-pressed-wins arbitration, divider load over valid/ready, and gate control.
module key_voice_arbiter #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DIV_W     = 18,
    parameter int unsigned DIV1      = 95556,
    parameter int unsigned DIV2      = 85131,
    parameter int unsigned DIV3      = 75843,
    parameter int unsigned DIV4      = 71586
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             k1,
    input  logic             k2,
    input  logic             k3,
    input  logic             k4,
    input  logic             cfg_ready,
    output logic             cfg_valid,
    output logic [DIV_W-1:0] cfg_div,
    output logic             gate,
    output logic [2:0]       note,
    output logic [3:0]       key_held
);

    typedef enum logic [1:0] {IDLE, LOAD, GAP, PLAY} state_t;

    localparam logic [15:0] DB_MAX = 16'(DB_CYCLES);

    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]       held_q, held_d, press;
    logic [15:0]      cnt_q [4];
    logic [15:0]      cnt_d [4];
    logic [2:0]       cand_q, cand_d;
    state_t           state_q, state_d;
    logic             valid_q, valid_d, gate_q, gate_d;
    logic [2:0]       note_q, note_d;
    logic [DIV_W-1:0] div_q, div_d;

    function automatic logic [2:0] top_key(input logic [3:0] v);
        if (v[3])      top_key = 3'd4;
        else if (v[2]) top_key = 3'd3;
        else if (v[1]) top_key = 3'd2;
        else if (v[0]) top_key = 3'd1;
        else           top_key = 3'd0;
    endfunction

    function automatic logic [3:0] key_mask(input logic [2:0] n);
        case (n)
            3'd1:    key_mask = 4'b0001;
            3'd2:    key_mask = 4'b0010;
            3'd3:    key_mask = 4'b0100;
            3'd4:    key_mask = 4'b1000;
            default: key_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] div_of(input logic [2:0] n);
        case (n)
            3'd1:    div_of = DIV_W'(DIV1);
            3'd2:    div_of = DIV_W'(DIV2);
            3'd3:    div_of = DIV_W'(DIV3);
            3'd4:    div_of = DIV_W'(DIV4);
            default: div_of = '0;
        endcase
    endfunction

    always_comb begin
        sync1_d = {k4, k3, k2, k1};
        sync2_d = sync1_q;
    end

    // A key flips only after its synchronised value has disagreed for DB_CYCLES counted cycles.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == held_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                held_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Candidate is updated on the same edge as key_held so the FSM reacts one edge later.
    always_comb begin
        press  = held_d & ~held_q;
        cand_d = cand_q;
        if (press != 4'b0000) begin
            cand_d = top_key(press);
        end else if ((held_d & key_mask(cand_q)) == 4'b0000) begin
            cand_d = top_key(held_d);
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        gate_d  = gate_q;
        note_d  = note_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                gate_d  = 1'b0;
                note_d  = 3'd0;
                if (cand_q != 3'd0) begin
                    note_d  = cand_q;
                    div_d   = div_of(cand_q);
                    valid_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                valid_d = 1'b1;
                if (cfg_ready) begin
                    valid_d = 1'b0;
                    if (cand_q == note_q) begin
                        gate_d  = 1'b1;
                        state_d = PLAY;
                    end else if (cand_q != 3'd0) begin
                        state_d = GAP;
                    end else begin
                        gate_d  = 1'b0;
                        note_d  = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                valid_d = 1'b0;
                if (cand_q != 3'd0) begin
                    note_d  = cand_q;
                    div_d   = div_of(cand_q);
                    valid_d = 1'b1;
                    state_d = LOAD;
                end else begin
                    gate_d  = 1'b0;
                    note_d  = 3'd0;
                    state_d = IDLE;
                end
            end
            PLAY: begin
                valid_d = 1'b0;
                gate_d  = 1'b1;
                if (cand_q == 3'd0) begin
                    gate_d  = 1'b0;
                    note_d  = 3'd0;
                    state_d = IDLE;
                end else if (cand_q != note_q) begin
                    note_d  = cand_q;
                    div_d   = div_of(cand_q);
                    valid_d = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            held_q  <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            cand_q  <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            gate_q  <= 1'b0;
            note_q  <= '0;
            div_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            cand_q  <= cand_d;
            state_q <= state_d;
            valid_q <= valid_d;
            gate_q  <= gate_d;
            note_q  <= note_d;
            div_q   <= div_d;
        end
    end

    assign cfg_valid = valid_q;
    assign cfg_div   = div_q;
    assign gate      = gate_q;
    assign note      = note_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_key_voice_arbiter.sv
// Directed bench for key_voice_arbiter: debounce latency, glitch rejection,
// last-pressed-wins arbitration and the divider handshake, checked on the falling edge.
module tb_key_voice_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        k1, k2, k3, k4;
    logic        cfg_ready;
    logic        cfg_valid;
    logic [17:0] cfg_div;
    logic        gate;
    logic [2:0]  note;
    logic [3:0]  key_held;

    int tests = 0;
    int fails = 0;

    key_voice_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .k1        (k1),
        .k2        (k2),
        .k3        (k3),
        .k4        (k4),
        .cfg_ready (cfg_ready),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .gate      (gate),
        .note      (note),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkFsm(input string tag, input logic ev, input logic eg, input logic [2:0] en);
        checkOutput({tag, ".valid"}, {31'd0, cfg_valid}, {31'd0, ev});
        checkOutput({tag, ".gate"},  {31'd0, gate},      {31'd0, eg});
        checkOutput({tag, ".note"},  {29'd0, note},      {29'd0, en});
    endtask

    initial begin
        rst = 1'b1; k1 = 1'b0; k2 = 1'b0; k3 = 1'b0; k4 = 1'b0; cfg_ready = 1'b1;
        applyStimulus(3);
        rst = 1'b0;
        checkFsm("reset", 1'b0, 1'b0, 3'd0);
        checkOutput("reset.div",  {14'd0, cfg_div}, 32'd0);
        checkOutput("reset.held", {28'd0, key_held}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1);
            checkOutput("idle", {25'd0, cfg_valid, gate, note, key_held}, 32'd0);
        end

        // Single key: k1 sampled at edge 0, held at edge 6, load at 7, gate at 8.
        k1 = 1'b1;
        applyStimulus(6);
        checkOutput("k1.held_e5", {28'd0, key_held}, 32'd0);
        applyStimulus(1);
        checkOutput("k1.held_e6", {28'd0, key_held}, 32'd1);
        checkFsm("k1.e6", 1'b0, 1'b0, 3'd0);
        applyStimulus(1);
        checkFsm("k1.e7", 1'b1, 1'b0, 3'd1);
        checkOutput("k1.div", {14'd0, cfg_div}, 32'd95556);
        applyStimulus(1);
        checkFsm("k1.e8", 1'b0, 1'b1, 3'd1);
        applyStimulus(3);
        k1 = 1'b0;
        applyStimulus(7);
        checkOutput("k1rel.held", {28'd0, key_held}, 32'd0);
        checkFsm("k1rel.e6", 1'b0, 1'b1, 3'd1);
        applyStimulus(1);
        checkFsm("k1rel.e7", 1'b0, 1'b0, 3'd0);

        // Three-cycle glitch on k2 never reaches key_held.
        k2 = 1'b1;
        applyStimulus(3);
        k2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            checkOutput("glitch", {26'd0, cfg_valid, gate, key_held}, 32'd0);
        end

        // Last-pressed wins: k1 then k3, then release k3 back to k1.
        k1 = 1'b1;
        applyStimulus(9);
        checkFsm("lpw.k1", 1'b0, 1'b1, 3'd1);
        k3 = 1'b1;
        applyStimulus(7);
        checkOutput("lpw.held13", {28'd0, key_held}, 32'd5);
        checkFsm("lpw.pre", 1'b0, 1'b1, 3'd1);
        applyStimulus(1);
        checkFsm("lpw.load3", 1'b1, 1'b1, 3'd3);
        checkOutput("lpw.div3", {14'd0, cfg_div}, 32'd75843);
        applyStimulus(1);
        checkFsm("lpw.play3", 1'b0, 1'b1, 3'd3);
        k3 = 1'b0;
        applyStimulus(7);
        checkOutput("lpw.held1", {28'd0, key_held}, 32'd1);
        applyStimulus(1);
        checkFsm("lpw.load1", 1'b1, 1'b1, 3'd1);
        checkOutput("lpw.div1", {14'd0, cfg_div}, 32'd95556);
        applyStimulus(1);
        checkFsm("lpw.play1", 1'b0, 1'b1, 3'd1);
        k1 = 1'b0;
        applyStimulus(8);
        checkFsm("lpw.off", 1'b0, 1'b0, 3'd0);

        // Simultaneous k2+k4: highest wins, then fall back to k2.
        k2 = 1'b1; k4 = 1'b1;
        applyStimulus(7);
        checkOutput("sim.held", {28'd0, key_held}, 32'd10);
        applyStimulus(1);
        checkFsm("sim.load4", 1'b1, 1'b0, 3'd4);
        checkOutput("sim.div4", {14'd0, cfg_div}, 32'd71586);
        applyStimulus(1);
        checkFsm("sim.play4", 1'b0, 1'b1, 3'd4);
        k4 = 1'b0;
        applyStimulus(7);
        checkOutput("sim.held2", {28'd0, key_held}, 32'd2);
        applyStimulus(1);
        checkFsm("sim.load2", 1'b1, 1'b1, 3'd2);
        checkOutput("sim.div2", {14'd0, cfg_div}, 32'd85131);
        applyStimulus(1);
        checkFsm("sim.play2", 1'b0, 1'b1, 3'd2);
        k2 = 1'b0;
        applyStimulus(7);
        checkFsm("sim.rel_e6", 1'b0, 1'b1, 3'd2);
        applyStimulus(1);
        checkFsm("sim.off", 1'b0, 1'b0, 3'd0);

        // Handshake stall: divider frozen while cfg_ready is low.
        cfg_ready = 1'b0;
        k1 = 1'b1;
        applyStimulus(8);
        checkFsm("stall.load1", 1'b1, 1'b0, 3'd1);
        checkOutput("stall.div1", {14'd0, cfg_div}, 32'd95556);
        k4 = 1'b1;
        applyStimulus(8);
        checkOutput("stall.held", {28'd0, key_held}, 32'd9);
        checkFsm("stall.hold", 1'b1, 1'b0, 3'd1);
        checkOutput("stall.div_hold", {14'd0, cfg_div}, 32'd95556);
        cfg_ready = 1'b1;
        applyStimulus(1);
        checkFsm("stall.gap", 1'b0, 1'b0, 3'd1);
        applyStimulus(1);
        checkFsm("stall.load4", 1'b1, 1'b0, 3'd4);
        checkOutput("stall.div4", {14'd0, cfg_div}, 32'd71586);
        applyStimulus(1);
        checkFsm("stall.play4", 1'b0, 1'b1, 3'd4);

        // Reload from PLAY with cfg_ready low keeps gate high, then reset mid-LOAD.
        cfg_ready = 1'b0;
        k4 = 1'b0;
        applyStimulus(7);
        checkFsm("rst.pre", 1'b0, 1'b1, 3'd4);
        applyStimulus(1);
        checkFsm("rst.load1", 1'b1, 1'b1, 3'd1);
        checkOutput("rst.div1", {14'd0, cfg_div}, 32'd95556);
        applyStimulus(3);
        checkFsm("rst.stuck", 1'b1, 1'b1, 3'd1);
        rst = 1'b1;
        applyStimulus(1);
        checkFsm("rst.mid", 1'b0, 1'b0, 3'd0);
        checkOutput("rst.div",  {14'd0, cfg_div}, 32'd0);
        checkOutput("rst.held", {28'd0, key_held}, 32'd0);
        rst = 1'b0;
        cfg_ready = 1'b1;
        applyStimulus(7);
        checkOutput("rst.reheld", {28'd0, key_held}, 32'd1);
        applyStimulus(1);
        checkFsm("rst.reload", 1'b1, 1'b0, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
